// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path constants: forward selects, halt FSM states, drain depth.
// Also a saturating 16-bit increment for the performance counters.
package cpu_ctrl_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } ctrl_state_t;

  localparam logic [1:0] DRAIN_DEPTH = 2'd3;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// ALU operand forward select for one EX source register.
// Ports: src, M/W dest+enable in; 2-bit sel out (MEM wins over WB).
module fwd_sel
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] addr_m,
  input  logic       en_m,
  input  logic [4:0] addr_w,
  input  logic       en_w,
  output logic [1:0] sel
);

  logic hit_m;
  logic hit_w;

  assign hit_m = en_m && (addr_m != 5'd0) && (addr_m == src);
  assign hit_w = en_w && (addr_w != 5'd0) && (addr_w == src);

  always_comb begin
    sel = FWD_REG;
    if (hit_m)      sel = FWD_MEM;
    else if (hit_w) sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding, load-use stall, branch flush, halt drain.
// Ports: ID/EX/MEM/WB reg fields in; stall/flush/fwd, Halted, perf counts out.
module hazard_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [4:0]  Rs_D,
  input  logic [4:0]  Rt_D,
  input  logic        Halt_D,
  input  logic [4:0]  Rs_E,
  input  logic [4:0]  Rt_E,
  input  logic [4:0]  RegAddr3_E,
  input  logic        RegWriteEN_E,
  input  logic        Mem2RegSEL_E,
  input  logic [4:0]  RegAddr3_M,
  input  logic        RegWriteEN_M,
  input  logic [4:0]  RegAddr3_W,
  input  logic        RegWriteEN_W,
  input  logic        PCSrc_M,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic [1:0]  FwdA_E,
  output logic [1:0]  FwdB_E,
  output logic        Halted,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount
);

  ctrl_state_t state_q, state_n;
  logic [1:0]  cnt_q, cnt_n;
  logic        halted_n;
  logic [1:0]  fwd_a, fwd_b;
  logic        load_use;

  fwd_sel u_fwd_a (
    .src    (Rs_E),
    .addr_m (RegAddr3_M),
    .en_m   (RegWriteEN_M),
    .addr_w (RegAddr3_W),
    .en_w   (RegWriteEN_W),
    .sel    (fwd_a)
  );

  fwd_sel u_fwd_b (
    .src    (Rt_E),
    .addr_m (RegAddr3_M),
    .en_m   (RegWriteEN_M),
    .addr_w (RegAddr3_W),
    .en_w   (RegWriteEN_W),
    .sel    (fwd_b)
  );

  assign load_use = RegWriteEN_E && Mem2RegSEL_E
                 && (RegAddr3_E != 5'd0)
                 && ((RegAddr3_E == Rs_D) || (RegAddr3_E == Rt_D))
                 && !Halt_D;

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    halted_n = Halted;
    StallF   = 1'b0;
    StallD   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    FlushM   = 1'b0;
    FwdA_E   = fwd_a;
    FwdB_E   = fwd_b;

    unique case (state_q)
      ST_RUN: begin
        if (load_use) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
        if (Halt_D && !PCSrc_M) begin
          state_n = ST_DRAIN;
          cnt_n   = DRAIN_DEPTH;
        end
      end
      ST_DRAIN: begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
        if (PCSrc_M) begin
          // halt was on the wrong path
          state_n = ST_RUN;
          cnt_n   = 2'd0;
        end else if (cnt_q == 2'd1) begin
          state_n  = ST_HALTED;
          cnt_n    = 2'd0;
          halted_n = 1'b1;
        end else begin
          cnt_n = cnt_q - 2'd1;
        end
      end
      ST_HALTED: begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
      default: begin
        state_n = ST_RUN;
        cnt_n   = 2'd0;
      end
    endcase

    // taken branch beats load-use and halt stalls
    if (PCSrc_M) begin
      StallF = 1'b0;
      StallD = 1'b0;
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
    end

    if (RESET) begin
      StallF = 1'b0;
      StallD = 1'b0;
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
      FwdA_E = FWD_REG;
      FwdB_E = FWD_REG;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= ST_RUN;
      cnt_q      <= 2'd0;
      Halted     <= 1'b0;
      StallCount <= 16'd0;
      FlushCount <= 16'd0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      Halted  <= halted_n;
      if (StallF) StallCount <= sat_inc(StallCount);
      if (FlushD) FlushCount <= sat_inc(FlushCount);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch, halt, reset.
// Each scenario task checks its own expected values inline.
module tb_hazard_ctrl;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [4:0]  Rs_D, Rt_D, Rs_E, Rt_E;
  logic        Halt_D;
  logic [4:0]  RegAddr3_E, RegAddr3_M, RegAddr3_W;
  logic        RegWriteEN_E, Mem2RegSEL_E;
  logic        RegWriteEN_M, RegWriteEN_W;
  logic        PCSrc_M;
  logic        StallF, StallD, FlushD, FlushE, FlushM;
  logic [1:0]  FwdA_E, FwdB_E;
  logic        Halted;
  logic [15:0] StallCount, FlushCount;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLOCK = ~CLOCK;

  hazard_ctrl dut (
    .CLOCK        (CLOCK),
    .RESET        (RESET),
    .Rs_D         (Rs_D),
    .Rt_D         (Rt_D),
    .Halt_D       (Halt_D),
    .Rs_E         (Rs_E),
    .Rt_E         (Rt_E),
    .RegAddr3_E   (RegAddr3_E),
    .RegWriteEN_E (RegWriteEN_E),
    .Mem2RegSEL_E (Mem2RegSEL_E),
    .RegAddr3_M   (RegAddr3_M),
    .RegWriteEN_M (RegWriteEN_M),
    .RegAddr3_W   (RegAddr3_W),
    .RegWriteEN_W (RegWriteEN_W),
    .PCSrc_M      (PCSrc_M),
    .StallF       (StallF),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .FlushM       (FlushM),
    .FwdA_E       (FwdA_E),
    .FwdB_E       (FwdB_E),
    .Halted       (Halted),
    .StallCount   (StallCount),
    .FlushCount   (FlushCount)
  );

  task automatic idle_inputs();
    Rs_D = 0; Rt_D = 0; Halt_D = 0;
    Rs_E = 0; Rt_E = 0;
    RegAddr3_E = 0; RegWriteEN_E = 0; Mem2RegSEL_E = 0;
    RegAddr3_M = 0; RegWriteEN_M = 0;
    RegAddr3_W = 0; RegWriteEN_W = 0;
    PCSrc_M = 0;
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    Rs_E = 5; RegAddr3_M = 5; RegWriteEN_M = 1;
    RESET = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({StallF, StallD} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_stall got=%b exp=00", {StallF, StallD});
    end
    n_checks++;
    if ({FlushD, FlushE, FlushM} !== 3'b111) begin
      n_fail++;
      $display("FAIL rst_flush got=%b exp=111", {FlushD, FlushE, FlushM});
    end
    n_checks++;
    if ({FwdA_E, FwdB_E} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_fwd got=%b exp=0000", {FwdA_E, FwdB_E});
    end
    n_checks++;
    if ({Halted, StallCount, FlushCount} !== 33'd0) begin
      n_fail++;
      $display("FAIL rst_state halted=%b sc=%0d fc=%0d exp=0", Halted, StallCount, FlushCount);
    end
    RESET = 1'b0;
    idle_inputs();
    #1;
    n_checks++;
    if ({StallF, FlushD, FlushE, FlushM} !== 4'b0000) begin
      n_fail++;
      $display("FAIL run_idle got=%b exp=0000", {StallF, FlushD, FlushE, FlushM});
    end
  endtask

  task automatic test_fwd();
    idle_inputs();
    Rs_E = 5; RegAddr3_M = 5; RegWriteEN_M = 1; RegAddr3_W = 5; RegWriteEN_W = 1;
    #1;
    n_checks++;
    if (FwdA_E !== 2'b10) begin
      n_fail++;
      $display("FAIL fwd_mem_prio got=%b exp=10", FwdA_E);
    end
    RegWriteEN_M = 0;
    #1;
    n_checks++;
    if (FwdA_E !== 2'b01) begin
      n_fail++;
      $display("FAIL fwd_wb got=%b exp=01", FwdA_E);
    end
    RegWriteEN_M = 1; RegAddr3_M = 0; RegAddr3_W = 0; Rs_E = 0;
    #1;
    n_checks++;
    if (FwdA_E !== 2'b00) begin
      n_fail++;
      $display("FAIL fwd_r0 got=%b exp=00", FwdA_E);
    end
    Rs_E = 5; RegAddr3_M = 6; RegAddr3_W = 7;
    #1;
    n_checks++;
    if (FwdA_E !== 2'b00) begin
      n_fail++;
      $display("FAIL fwd_nomatch got=%b exp=00", FwdA_E);
    end
    Rt_E = 7;
    #1;
    n_checks++;
    if ({FwdA_E, FwdB_E} !== 4'b0001) begin
      n_fail++;
      $display("FAIL fwdb_wb got=%b exp=0001", {FwdA_E, FwdB_E});
    end
    Rt_E = 6; RegWriteEN_W = 0;
    #1;
    n_checks++;
    if (FwdB_E !== 2'b10) begin
      n_fail++;
      $display("FAIL fwdb_mem got=%b exp=10", FwdB_E);
    end
    idle_inputs();
    #1;
  endtask

  task automatic test_load_use();
    do_reset();
    RegAddr3_E = 8; RegWriteEN_E = 1; Mem2RegSEL_E = 1;
    Rs_D = 9; Rt_D = 8;
    #1;
    n_checks++;
    if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) begin
      n_fail++;
      $display("FAIL lu_stall got=%b exp=1110", {StallF, StallD, FlushE, FlushD});
    end
    tick();
    idle_inputs();
    Rs_D = 9; Rt_D = 8;
    #1;
    n_checks++;
    if ({StallF, StallD, FlushE} !== 3'b000) begin
      n_fail++;
      $display("FAIL lu_release got=%b exp=000", {StallF, StallD, FlushE});
    end
    n_checks++;
    if ({StallCount, FlushCount} !== {16'd1, 16'd0}) begin
      n_fail++;
      $display("FAIL lu_count sc=%0d fc=%0d exp=1,0", StallCount, FlushCount);
    end
    RegAddr3_E = 8; RegWriteEN_E = 1; Mem2RegSEL_E = 0;
    #1;
    n_checks++;
    if (StallF !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_noload got=%b exp=0", StallF);
    end
    RegAddr3_E = 0; Mem2RegSEL_E = 1; Rs_D = 0; Rt_D = 0;
    #1;
    n_checks++;
    if (StallF !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_r0 got=%b exp=0", StallF);
    end
    idle_inputs();
  endtask

  task automatic test_branch_load_use();
    do_reset();
    RegAddr3_E = 8; RegWriteEN_E = 1; Mem2RegSEL_E = 1; Rt_D = 8;
    PCSrc_M = 1;
    #1;
    n_checks++;
    if ({FlushD, FlushE, FlushM, StallF, StallD} !== 5'b11100) begin
      n_fail++;
      $display("FAIL br_lu got=%b exp=11100", {FlushD, FlushE, FlushM, StallF, StallD});
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if ({FlushCount, StallCount} !== {16'd1, 16'd0}) begin
      n_fail++;
      $display("FAIL br_count fc=%0d sc=%0d exp=1,0", FlushCount, StallCount);
    end
  endtask

  task automatic test_halt();
    do_reset();
    Halt_D = 1;
    #1;
    n_checks++;
    if (StallF !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_run got=%b exp=0", StallF);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++;
      if ({StallF, StallD, FlushE, Halted} !== 4'b1110) begin
        n_fail++;
        $display("FAIL halt_drain%0d got=%b exp=1110", i, {StallF, StallD, FlushE, Halted});
      end
    end
    tick();
    Halt_D = 0;
    #1;
    n_checks++;
    if ({Halted, StallF, FlushE} !== 3'b111) begin
      n_fail++;
      $display("FAIL halt_enter got=%b exp=111", {Halted, StallF, FlushE});
    end
    n_checks++;
    if (StallCount !== 16'd3) begin
      n_fail++;
      $display("FAIL halt_sc got=%0d exp=3", StallCount);
    end
    tick();
    tick();
    n_checks++;
    if ({Halted, StallCount} !== {1'b1, 16'd5}) begin
      n_fail++;
      $display("FAIL halt_hold halted=%b sc=%0d exp=1,5", Halted, StallCount);
    end
  endtask

  task automatic test_reset_halted();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    #1;
    n_checks++;
    if ({Halted, StallCount, FlushCount} !== 33'd0) begin
      n_fail++;
      $display("FAIL rsth_state halted=%b sc=%0d fc=%0d exp=0", Halted, StallCount, FlushCount);
    end
    n_checks++;
    if ({StallF, FlushE} !== 2'b00) begin
      n_fail++;
      $display("FAIL rsth_run got=%b exp=00", {StallF, FlushE});
    end
    tick();
    n_checks++;
    if ({StallF, Halted} !== 2'b00) begin
      n_fail++;
      $display("FAIL rsth_run2 got=%b exp=00", {StallF, Halted});
    end
  endtask

  task automatic test_cancel();
    do_reset();
    Halt_D = 1;
    tick();
    tick();
    Halt_D = 0;
    PCSrc_M = 1;
    #1;
    n_checks++;
    if ({FlushD, FlushE, FlushM, StallF} !== 4'b1110) begin
      n_fail++;
      $display("FAIL cancel_flush got=%b exp=1110", {FlushD, FlushE, FlushM, StallF});
    end
    tick();
    PCSrc_M = 0;
    #1;
    n_checks++;
    if ({StallF, FlushE, Halted} !== 3'b000) begin
      n_fail++;
      $display("FAIL cancel_run got=%b exp=000", {StallF, FlushE, Halted});
    end
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if ({StallF, Halted} !== 2'b00) begin
      n_fail++;
      $display("FAIL cancel_hold got=%b exp=00", {StallF, Halted});
    end
  endtask

  task automatic test_saturate();
    do_reset();
    Halt_D = 1;
    tick();
    Halt_D = 0;
    for (int i = 0; i < 65540; i++) @(posedge CLOCK);
    #1;
    n_checks++;
    if (StallCount !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_sc got=%h exp=ffff", StallCount);
    end
    do_reset();
  endtask

  initial begin
    idle_inputs();
    RESET = 1'b1;
    test_reset();
    test_fwd();
    test_load_use();
    test_branch_load_use();
    test_halt();
    test_reset_halted();
    test_cancel();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
